// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-2 buffered demultiplexer.
// The optional statistics feature is controlled by DEMUX_STATS_EN in the top module.
package demux_pkg;

  localparam int DEMUX_WIDTH = 64;
  localparam int DEMUX_DEPTH = 2;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } chan_e;

  // A one-entry FIFO would still need a one-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int DEMUX_PTR_W = ptr_width(DEMUX_DEPTH);

endpackage

// File: rtl/demux_chan_fifo.sv
// Per-channel synchronous FIFO with registered count and no read bypass.
// DEPTH must be a power of two, so the pointers wrap naturally.
module demux_chan_fifo
  import demux_pkg::*;
#(
  parameter  int WIDTH = DEMUX_WIDTH,
  parameter  int DEPTH = DEMUX_DEPTH,
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_DEPTH);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Output comes straight from storage: no combinational path from i_data.
  assign o_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset so out*_data reads 0 after reset; a small array
      // keeps that cheap, where a deep RAM would normally be left unreset.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments ensure every branch sees pre-edge state.
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/demux1t2_64_buf.sv
// Registered 1-to-2 demux: steers each accepted word into one of two channel FIFOs.
// Define DEMUX_STATS_EN to add per-channel delivered-word counters (stat0_cnt/stat1_cnt).
module demux1t2_64_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int DEPTH = DEMUX_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_STATS_EN
  ,
  output logic [31:0]      stat0_cnt,
  output logic [31:0]      stat1_cnt
`endif
);

  chan_e w_sel;
  logic  w_full0, w_full1;
  logic  w_empty0, w_empty1;
  logic  w_accept;
  logic  w_push0, w_push1;
  logic  w_pop0, w_pop1;

  assign w_sel = chan_e'(in_sel);

  // Ready depends only on the select and registered fullness, never on outX_ready.
  assign in_ready = (w_sel == CH0) ? !w_full0 : !w_full1;
  assign w_accept = in_valid && in_ready;
  assign w_push0  = w_accept && (w_sel == CH0);
  assign w_push1  = w_accept && (w_sel == CH1);

  assign out0_valid = !w_empty0;
  assign out1_valid = !w_empty1;
  assign w_pop0     = out0_valid && out0_ready;
  assign w_pop1     = out1_valid && out1_ready;

  demux_chan_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push0),
    .i_data (in_data),
    .i_pop  (w_pop0),
    .o_data (out0_data),
    .o_full (w_full0),
    .o_empty(w_empty0)
  );

  demux_chan_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push1),
    .i_data (in_data),
    .i_pop  (w_pop1),
    .o_data (out1_data),
    .o_full (w_full1),
    .o_empty(w_empty1)
  );

`ifdef DEMUX_STATS_EN
  logic [31:0] r_stat0_cnt;
  logic [31:0] r_stat1_cnt;

  // Counters wrap silently at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat0_cnt <= '0;
      r_stat1_cnt <= '0;
    end else begin
      if (w_pop0) r_stat0_cnt <= r_stat0_cnt + 32'd1;
      if (w_pop1) r_stat1_cnt <= r_stat1_cnt + 32'd1;
    end
  end

  assign stat0_cnt = r_stat0_cnt;
  assign stat1_cnt = r_stat1_cnt;
`endif

endmodule

// File: tb/tb_demux1t2_64_buf.sv
// Scoreboard bench for demux1t2_64_buf: stimulus queues expected words, a monitor checks deliveries.
module tb_demux1t2_64_buf;
  import demux_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sel = 1'b0;
  logic [63:0] in_data = '0;
  logic        out0_valid, out1_valid;
  logic        out0_ready = 1'b0;
  logic        out1_ready = 1'b0;
  logic [63:0] out0_data, out1_data;
`ifdef DEMUX_STATS_EN
  logic [31:0] stat0_cnt, stat1_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] exp0[$];
  logic [63:0] exp1[$];

  always #5 clk = ~clk;

  demux1t2_64_buf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out0_data (out0_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .out1_data (out1_data)
`ifdef DEMUX_STATS_EN
    ,
    .stat0_cnt (stat0_cnt),
    .stat1_cnt (stat1_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns after the accepting edge.
  task automatic push_word(input logic sel, input logic [63:0] d, output int waits);
    waits = 0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      check("push_timeout", 64'(waits), 64'd0);
    end else if (sel) begin
      exp1.push_back(d);
    end else begin
      exp0.push_back(d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every handshake about to occur on the next edge pops the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out0_valid && out0_ready) begin
        if (exp0.size() == 0) check("ch0_unexpected_word", out0_data, 64'd0 - 64'd1);
        else check("ch0_data", out0_data, exp0.pop_front());
      end
      if (out1_valid && out1_ready) begin
        if (exp1.size() == 0) check("ch1_unexpected_word", out1_data, 64'd0 - 64'd1);
        else check("ch1_data", out1_data, exp1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    logic [3:0] pat;
`ifdef DEMUX_STATS_EN
    logic [31:0] s1_before;
`endif
    pat = 4'b1011;

    // Reset, then load cnt0=2, cnt1=1 with consumers stalled.
    #12 rst_n = 1'b1;
    tick();
    push_word(1'b0, 64'h1111_0000_0000_0001, w);
    push_word(1'b0, 64'h1111_0000_0000_0002, w);
    push_word(1'b1, 64'h2222_0000_0000_0001, w);
    check("pre_reset_out0_valid", 64'(out0_valid), 64'd1);
    check("pre_reset_out1_valid", 64'(out1_valid), 64'd1);
    in_sel = 1'b0;
    #1 check("pre_reset_ready_sel0_full", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("reset_out0_valid", 64'(out0_valid), 64'd0);
    check("reset_out1_valid", 64'(out1_valid), 64'd0);
    check("reset_out0_data", out0_data, 64'd0);
    check("reset_out1_data", out1_data, 64'd0);
    exp0.delete();
    exp1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    in_sel = 1'b0;
    #1 check("post_reset_ready_sel0", 64'(in_ready), 64'd1);
    in_sel = 1'b1;
    #1 check("post_reset_ready_sel1", 64'(in_ready), 64'd1);
    tick();

    // Latency and steering.
    out0_ready = 1'b1;
    push_word(1'b0, 64'h0123_4567_89AB_CDEF, w);
    check("latency_out0_valid", 64'(out0_valid), 64'd1);
    check("latency_out1_valid", 64'(out1_valid), 64'd0);
    tick();
    check("latency_popped", 64'(out0_valid), 64'd0);

    // Backpressure on channel 1 does not block channel 0.
    out1_ready = 1'b0;
    push_word(1'b1, 64'h0000_0000_0000_00A1, w);
    push_word(1'b1, 64'h0000_0000_0000_00A2, w);
    in_sel = 1'b1;
    #1 check("bp_ready_sel1_full", 64'(in_ready), 64'd0);
    in_sel = 1'b0;
    #1 check("bp_ready_sel0_open", 64'(in_ready), 64'd1);
    push_word(1'b0, 64'h0000_0000_0000_00B1, w);
    check("bp_ch0_push_no_wait", 64'(w), 64'd0);
    check("bp_ch1_head_held", out1_data, 64'h0000_0000_0000_00A1);
    out1_ready = 1'b1;
    repeat (3) tick();
    check("bp_ch1_drained", 64'(out1_valid), 64'd0);

    // Full channel with a same-cycle pop: one bubble before the accept.
    out0_ready = 1'b0;
    push_word(1'b0, 64'h0000_0000_0000_00C1, w);
    push_word(1'b0, 64'h0000_0000_0000_00C2, w);
    in_sel = 1'b0;
    #1 check("full_ready_low", 64'(in_ready), 64'd0);
    out0_ready = 1'b1;
    push_word(1'b0, 64'h0000_0000_0000_00C3, w);
    check("full_pop_bubble_waits", 64'(w), 64'd1);
    repeat (3) tick();
    check("full_drained", 64'(out0_valid), 64'd0);

    // Streaming with wrap: alternating channels under a 1,0,1,1 ready pattern.
    fork
      begin
        for (int i = 0; i < 16; i++)
          push_word(i[0], 64'hC0DE_0000_0000_0000 + 64'(i), w);
      end
      begin
        for (int c = 0; c < 48; c++) begin
          out0_ready = pat[3 - (c % 4)];
          out1_ready = pat[3 - ((c + 1) % 4)];
          tick();
        end
      end
    join
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    repeat (6) tick();
    check("stream_ch0_all_delivered", 64'(exp0.size()), 64'd0);
    check("stream_ch1_all_delivered", 64'(exp1.size()), 64'd0);
    check("stream_out0_idle", 64'(out0_valid), 64'd0);
    check("stream_out1_idle", 64'(out1_valid), 64'd0);

`ifdef DEMUX_STATS_EN
    // Counter wrap: preload 0xFFFFFFFE, three pops on channel 0 end at 1.
    s1_before = stat1_cnt;
    force dut.r_stat0_cnt = 32'hFFFF_FFFE;
    #1 release dut.r_stat0_cnt;
    for (int i = 0; i < 3; i++) push_word(1'b0, 64'h57A7_0000_0000_0000 + 64'(i), w);
    repeat (3) tick();
    check("stats_stat0_wrap", 64'(stat0_cnt), 64'd1);
    check("stats_stat1_unchanged", 64'(stat1_cnt), 64'(s1_before));
`endif

    check("final_ch0_queue_empty", 64'(exp0.size()), 64'd0);
    check("final_ch1_queue_empty", 64'(exp1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux1t2_64_buf.md
Name: demux1t2_64_buf

Overview:
- Registered 1-to-2 demultiplexer for a 64-bit word stream. It is the steering counterpart of the 64-bit 2:1 select mux.
- Takes one valid/ready input channel and routes each accepted word to output channel 0 or 1 according to a per-word select bit.
- Each output channel has its own small FIFO, so a stalled consumer blocks only traffic aimed at it.
- Sits in the pipeline datapath wherever a 64-bit result must be delivered to one of two consumers, for example the writeback path versus the memory store path.

Parameters:
- WIDTH, 64, data word width in bits.
- DEPTH, 2, entries per output FIFO; must be a power of two and at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts the word this cycle.
- in_sel  input  1  destination: 0 selects out0, 1 selects out1.
- in_data  input  WIDTH  input word.
- out0_valid  output  1  head of channel-0 FIFO is valid.
- out0_ready  input  1  consumer 0 takes the head word.
- out0_data  output  WIDTH  channel-0 head word.
- out1_valid  output  1  head of channel-1 FIFO is valid.
- out1_ready  input  1  consumer 1 takes the head word.
- out1_data  output  WIDTH  channel-1 head word.
- stat0_cnt  output  32  words delivered on channel 0 (DEMUX_STATS_EN only).
- stat1_cnt  output  32  words delivered on channel 1 (DEMUX_STATS_EN only).

Behaviour:
- Clock and reset: single clock domain. rst_n is asynchronous and active-low.
- Reset values, applied immediately on rst_n low: FIFO counts 0, read and write pointers 0, storage 0, outX_valid 0, outX_data 0, stat counters 0.
- Reset mid-operation discards all buffered words; nothing is replayed.
- Per-channel state: count in 0..DEPTH, write pointer, read pointer. Pointers wrap modulo DEPTH.
- in_ready = (in_sel == 0) ? (cnt0 != DEPTH) : (cnt1 != DEPTH).
  - Combinational from in_sel and registered counts only.
  - No combinational path from outX_ready to in_ready.
- Accept: in_valid and in_ready high at a clock edge. The word is written at the selected channel's write pointer, and that pointer and count increment.
- Latency: a word accepted at edge N is presented on outX_valid/outX_data after edge N (visible from cycle N+1). There is no combinational in-to-out bypass.
- Pop: outX_valid and outX_ready high at an edge advance the read pointer and decrement the count.
- outX_valid = (cntX != 0). outX_data = storage[rd_ptrX]. Data is held stable while valid is high and ready is low.
- Simultaneous push and pop on the same channel: count unchanged, both pointers advance.
  - At count DEPTH, in_ready is already low, so a same-cycle pop does not admit a push. This costs one bubble and is accepted by design.
  - At count 0, a push and pop cannot coincide because valid is low.
- Pushing to one channel while the other pops is fully independent.
- Ordering: per-channel FIFO order is preserved. No ordering is guaranteed between channels.
- While in_valid is low, in_ready still reflects the in_sel value; the upstream stage must hold in_sel and in_data stable while in_valid is high and in_ready is low.
- Full throughput: one word per cycle when consumers keep ready high.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined: stat0_cnt and stat1_cnt exist. Each increments by 1 on every pop of its channel, wraps 0xFFFFFFFF to 0, and resets to 0.
- Not defined: the stat ports and counters are absent. Datapath behaviour is identical.

Decomposition:
- Shared package demux_pkg holds:
  - WIDTH default 64 and DEPTH default 2.
  - Channel index constants CH0=0 and CH1=1.
  - Pointer width constant derived as log2(DEPTH).
- One sub-module, demux_chan_fifo (synchronous FIFO with count, full, empty, push, pop, async active-low reset), instantiated twice.
- The top level holds the select/ready steering and the optional statistic counters.

Test Plan:
- Reset: assert rst_n=0 mid-stream with cnt0=2 and cnt1=1 -> out0_valid=0, out1_valid=0, both data outputs 0 immediately; in_ready=1 after release for either sel.
- Latency and steering: push 0x0123456789ABCDEF with sel=0 and out0_ready=1 -> out0_valid=1 with that data on the next cycle, popped that cycle; out1_valid stays 0.
- Backpressure full: out1_ready=0, push 0xA1 then 0xA2 to sel=1 -> in_ready=0 for sel=1 while in_ready=1 for sel=0; a push of 0xB1 to channel 0 still succeeds; then out1_ready=1 -> 0xA1 then 0xA2 in order.
- Full with same-cycle pop: channel 0 full, out0_ready=1 and in_valid=1 with sel=0 -> no accept that cycle, count drops to 1, accept on the next cycle.
- Streaming wrap: 16 words alternating sel 0/1 with ready pattern 1,0,1,1 -> every word delivered once on the correct channel in order; pointers wrap with no loss or duplication.
- Stats (DEMUX_STATS_EN): preload a counter by forcing it to 0xFFFFFFFE, pop 3 words on channel 0 -> stat0_cnt=1 and stat1_cnt unchanged.
